// File: rtl/pc_branch_unit.sv
// Program counter register with next-PC resolution: conditional branches, direct and
// register-indirect jumps, stall hold, misaligned-target trap and saturating branch counters.
module pc_branch_unit #(
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_VEC  = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VEC   = 32'h0000_0010,
  parameter int                ALIGN_BITS = 2,
  parameter int                CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             VALID,
  input  logic [2:0]       OPCODE,
  input  logic             Z,
  input  logic [XLEN-1:0]  D,
  input  logic [XLEN-1:0]  IMM,
  input  logic [XLEN-1:0]  RS1,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PC_LINK,
  output logic             TAKEN,
  output logic             MISALIGN,
  output logic [XLEN-1:0]  BAD_ADDR,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] TK_CNT
);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_ZER  = 3'd1,
    OP_NZR  = 3'd2,
    OP_DAT  = 3'd3,
    OP_NDT  = 3'd4,
    OP_JMP  = 3'd5,
    OP_JMPR = 3'd6,
    OP_RSV  = 3'd7
  } op_t;

  logic [XLEN-1:0]  pc_reg;
  logic             taken_reg;
  logic             misalign_reg;
  logic [XLEN-1:0]  bad_addr_reg;
  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] tk_cnt_reg;

  op_t             op;
  logic            is_cond;
  logic            take;
  logic [XLEN-1:0] target;
  logic            misaligned_bits;
  logic            trap;
  logic [XLEN-1:0] pc_next;

  // An invalid slot behaves exactly like a sequential instruction.
  assign op = VALID ? op_t'(OPCODE) : OP_SEQ;

  always_comb begin
    is_cond = 1'b0;
    take    = 1'b0;
    target  = pc_reg + IMM;
    case (op)
      OP_ZER:  begin is_cond = 1'b1; take = Z;    end
      OP_NZR:  begin is_cond = 1'b1; take = !Z;   end
      OP_DAT:  begin is_cond = 1'b1; take = |D;   end
      OP_NDT:  begin is_cond = 1'b1; take = ~|D;  end
      OP_JMP:  take = 1'b1;
      OP_JMPR: begin
        take   = 1'b1;
        target = (RS1 + IMM) & ~{{(XLEN-1){1'b0}}, 1'b1};
      end
      default: take = 1'b0;
    endcase
  end

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misaligned_bits = |target[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misaligned_bits = 1'b0;
    end
  endgenerate

  // Only a taken target is checked; the fall-through path is always aligned by construction.
  assign trap    = take && misaligned_bits;
  assign pc_next = trap ? TRAP_VEC : (take ? target : pc_reg + XLEN'(4));

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg       <= RESET_VEC;
      taken_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      bad_addr_reg <= '0;
      br_cnt_reg   <= '0;
      tk_cnt_reg   <= '0;
    end else if (STALL) begin
      taken_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      taken_reg    <= take && !trap;
      misalign_reg <= trap;
      if (trap) begin
        bad_addr_reg <= target;
      end
      // Counters stick at all-ones rather than wrapping.
      if (is_cond && (br_cnt_reg != '1)) begin
        br_cnt_reg <= br_cnt_reg + 1'b1;
      end
      if (is_cond && take && (tk_cnt_reg != '1)) begin
        tk_cnt_reg <= tk_cnt_reg + 1'b1;
      end
    end
  end

  assign PC       = pc_reg;
  assign PC_LINK  = pc_reg + XLEN'(4);
  assign TAKEN    = taken_reg;
  assign MISALIGN = misalign_reg;
  assign BAD_ADDR = bad_addr_reg;
  assign BR_CNT   = br_cnt_reg;
  assign TK_CNT   = tk_cnt_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the next-PC rules.
module tb_pc_branch_unit;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] TRAP = 32'h0000_0010;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        VALID = 1'b0;
  logic [2:0]  OPCODE = 3'd0;
  logic        Z = 1'b0;
  logic [31:0] D = '0;
  logic [31:0] IMM = '0;
  logic [31:0] RS1 = '0;
  logic [31:0] PC, PC_LINK, BAD_ADDR;
  logic        TAKEN, MISALIGN;
  logic [CNT_W-1:0] BR_CNT, TK_CNT;

  always #5 CLK = ~CLK;

  pc_branch_unit #(
    .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(TRAP), .ALIGN_BITS(2), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .VALID(VALID), .OPCODE(OPCODE),
    .Z(Z), .D(D), .IMM(IMM), .RS1(RS1),
    .PC(PC), .PC_LINK(PC_LINK), .TAKEN(TAKEN), .MISALIGN(MISALIGN),
    .BAD_ADDR(BAD_ADDR), .BR_CNT(BR_CNT), .TK_CNT(TK_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, advanced once per rising edge from the architectural rules.
  logic [31:0] m_pc = '0, m_bad = '0;
  logic        m_taken = 1'b0, m_mis = 1'b0;
  int          m_br = 0, m_tk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int          op;
    bit          cond, tk;
    logic [31:0] tgt;
    if (RST) begin
      m_pc = 32'h0; m_taken = 0; m_mis = 0; m_bad = 0; m_br = 0; m_tk = 0;
    end else if (STALL) begin
      m_taken = 0; m_mis = 0;
    end else begin
      op   = VALID ? int'(OPCODE) : 0;
      cond = (op >= 1) && (op <= 4);
      tk   = (op == 1 && Z) || (op == 2 && !Z) || (op == 3 && D != 0) ||
             (op == 4 && D == 0) || op == 5 || op == 6;
      tgt  = (op == 6) ? ((RS1 + IMM) & 32'hFFFF_FFFE) : (m_pc + IMM);
      if (tk && (tgt % 4) != 0) begin
        m_pc = TRAP; m_mis = 1; m_taken = 0; m_bad = tgt;
      end else begin
        m_pc = tk ? tgt : m_pc + 4; m_mis = 0; m_taken = tk;
      end
      if (cond) begin
        m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
        if (tk) m_tk = (m_tk < CNT_MAX) ? m_tk + 1 : CNT_MAX;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs 1 ns later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("pc", PC, m_pc);
    check("pc_link", PC_LINK, m_pc + 32'd4);
    check("taken", 32'(TAKEN), 32'(m_taken));
    check("misalign", 32'(MISALIGN), 32'(m_mis));
    check("bad_addr", BAD_ADDR, m_bad);
    check("br_cnt", 32'(BR_CNT), 32'(m_br));
    check("tk_cnt", 32'(TK_CNT), 32'(m_tk));
  endtask

  task automatic drive(input bit rst, input bit stall, input bit valid, input int op,
                       input bit z, input logic [31:0] d, input logic [31:0] imm,
                       input logic [31:0] rs1);
    RST = rst; STALL = stall; VALID = valid; OPCODE = 3'(op);
    Z = z; D = d; IMM = imm; RS1 = rs1;
  endtask

  initial begin
    // Reset wins over stall and a pending jump.
    drive(1, 1, 1, 5, 0, 0, 32'h100, 0);
    step(); step();
    check("rst_pc", PC, 32'h0);
    check("rst_link", PC_LINK, 32'h4);
    check("rst_taken", 32'(TAKEN), 0);
    check("rst_mis", 32'(MISALIGN), 0);
    check("rst_cnt", 32'({BR_CNT, TK_CNT}), 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); check("seq_pc4", PC, 32'h4);
    step(); check("seq_pc8", PC, 32'h8);
    step(); check("seq_pcc", PC, 32'hC);

    drive(0, 1, 1, 5, 0, 0, 32'h100, 0);
    step(); check("stall_pc", PC, 32'hC); check("stall_taken", 32'(TAKEN), 0);
    step(); check("stall_pc2", PC, 32'hC);

    drive(0, 0, 1, 5, 0, 0, 32'h14, 0);
    step(); check("jmp_pc", PC, 32'h20); check("jmp_taken", 32'(TAKEN), 1);

    drive(0, 0, 1, 1, 1, 0, 32'hFFFF_FFF8, 0);
    step();
    check("zer_pc", PC, 32'h18); check("zer_taken", 32'(TAKEN), 1);
    check("zer_br", 32'(BR_CNT), 1); check("zer_tk", 32'(TK_CNT), 1);

    drive(0, 0, 1, 4, 0, 32'h5, 32'hFFFF_FFF8, 0);
    step();
    check("ndt_pc", PC, 32'h1C); check("ndt_taken", 32'(TAKEN), 0);
    check("ndt_br", 32'(BR_CNT), 2); check("ndt_tk", 32'(TK_CNT), 1);

    drive(0, 0, 1, 6, 0, 0, 32'h3, 32'h1001);
    step(); check("jmpr_pc", PC, 32'h1004); check("jmpr_taken", 32'(TAKEN), 1);

    drive(0, 0, 1, 6, 0, 0, 32'h6, 32'h1000);
    step();
    check("trap_pc", PC, TRAP); check("trap_mis", 32'(MISALIGN), 1);
    check("trap_bad", BAD_ADDR, 32'h1006); check("trap_taken", 32'(TAKEN), 0);

    drive(0, 0, 1, 1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) step();
    check("sat_br", 32'(BR_CNT), 15); check("sat_tk", 32'(TK_CNT), 15);

    drive(0, 0, 1, 5, 0, 0, 32'hFFFF_FFEC, 0);
    step(); check("top_pc", PC, 32'hFFFF_FFFC); check("top_link", PC_LINK, 32'h0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step(); check("wrap_pc", PC, 32'h0);

    // Misaligned DAT on the same edge as reset is discarded.
    drive(1, 0, 1, 3, 0, 32'h1, 32'h2, 0);
    step();
    check("rtrap_pc", PC, 32'h0); check("rtrap_mis", 32'(MISALIGN), 0);
    check("rtrap_bad", BAD_ADDR, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm, rs1, d;
      int op;
      op  = int'($urandom_range(0, 7));
      imm = {$urandom_range(0, 1) ? 28'hFFF_FFFF : 28'h0, 4'h0} | 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
      rs1 = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rs1 = rs1 | 32'($urandom_range(1, 3));
      if (op == 6) begin
        imm = imm & 32'hFFFF_FFFE;
        rs1 = rs1 & 32'hFFFF_FFFE;
      end
      d = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, op, 1'($urandom_range(0, 1)), d, imm, rs1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised successor to the combinational branch-increment logic.
- Owns the architectural program counter register and resolves the next PC each cycle, using ALU flags/data plus the branch opcode.
- Adds register-indirect jumps, stall hold, misaligned-target trapping with a captured fault address, and saturating branch statistics counters.
- Sits between the ALU/decode stage and instruction fetch of the RISCV_CPU.

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0010, PC value loaded on a misaligned target.
- ALIGN_BITS, 2, number of low target bits that must be zero (2 = word aligned).
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- STALL  input  1  hold PC and counters this cycle.
- VALID  input  1  OPCODE/flags describe a real instruction this cycle.
- OPCODE  input  3  branch operation (encoding below).
- Z  input  1  ALU zero flag.
- D  input  XLEN  ALU result (reduced for DAT/NDT).
- IMM  input  XLEN  sign-extended immediate offset.
- RS1  input  XLEN  base register for indirect jump.
- PC  output  XLEN  current program counter (registered).
- PC_LINK  output  XLEN  PC+4, combinational, link value for JAL/JALR.
- TAKEN  output  1  registered; 1 for the cycle after a taken branch/jump commits.
- MISALIGN  output  1  registered; 1 for one cycle after a trap commits.
- BAD_ADDR  output  XLEN  target that caused the most recent misalign trap.
- BR_CNT  output  CNT_W  count of committed conditional branches.
- TK_CNT  output  CNT_W  count of committed taken conditional branches.

Behaviour:
- Opcode encoding:
  - 0 SEQ: not taken.
  - 1 ZER: taken if Z.
  - 2 NZR: taken if !Z.
  - 3 DAT: taken if |D.
  - 4 NDT: taken if ~|D.
  - 5 JMP: always taken, target PC+IMM.
  - 6 JMPR: always taken, target (RS1+IMM) with bit0 cleared.
  - 7: reserved, treated as SEQ.
- Condition evaluation:
  - Conditional target (opcodes 1-4) is PC+IMM.
  - If VALID=0, the opcode is treated as SEQ.
- All adds are modulo 2^XLEN; wrap-around is silent (PC=FFFF_FFFC, SEQ gives 0).
- Misalignment:
  - Applies only to a taken target with any of bits [ALIGN_BITS-1:0] non-zero (after the JMPR bit0 clear).
  - The next PC is TRAP_VEC, BAD_ADDR captures the raw target, MISALIGN=1 and TAKEN=0 next cycle.
  - SEQ is never checked.
- Commit rule: at each rising edge with RST=0 and STALL=0, PC <= next PC, TAKEN/MISALIGN update, and counters update.
- Stall: with STALL=1, PC, BAD_ADDR and counters hold, and TAKEN and MISALIGN are forced to 0 next cycle. Stalled instructions are never counted, even if VALID=1.
- Counters:
  - BR_CNT increments on each committed valid opcode 1-4.
  - TK_CNT increments when that branch is taken, including taken-but-misaligned.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - JMP/JMPR are not counted.
- Reset: RST has priority over STALL. Next edge gives PC=RESET_VEC, TAKEN=0, MISALIGN=0, BAD_ADDR=0, BR_CNT=0, TK_CNT=0. Reset asserted mid-stall or mid-trap discards the pending target.
- Latency: single-cycle. A decision presented in cycle N is visible on PC in cycle N+1, with no bubbles inserted by this block.
- PC_LINK follows PC combinationally, including during reset and stall.

Test Plan:
- Reset: hold RST 2 cycles with STALL=1, VALID=1, OPCODE=5 -> PC=0x0, all counters 0, TAKEN=0, MISALIGN=0, PC_LINK=0x4.
- Sequential/stall: 3 cycles VALID=0 -> PC 0x4, 0x8, 0xC; then STALL=1 for 2 cycles with OPCODE=5, IMM=0x100 -> PC stays 0xC, TAKEN=0.
- Conditional:
  - At PC=0x20, ZER Z=1 IMM=-8 -> PC=0x18, TAKEN=1, BR_CNT=1, TK_CNT=1.
  - Then NDT with D=0x5 -> PC=0x1C, TAKEN=0, BR_CNT=2, TK_CNT=1.
- Indirect: JMPR RS1=0x1001, IMM=0x3 -> PC=0x1004, TAKEN=1; JMPR RS1=0x1000, IMM=0x6 -> PC=0x10, MISALIGN=1, BAD_ADDR=0x1006, TAKEN=0.
- Saturation/wrap (CNT_W=4): 20 committed taken ZER branches -> BR_CNT=TK_CNT=15. At PC=0xFFFF_FFFC with SEQ -> PC=0x0.
- Reset mid-trap: misaligned DAT commit with RST=1 on the same edge -> PC=0x0, MISALIGN=0, BAD_ADDR=0.
